// File: rtl/lisnoc_link_tx.sv
// -----------------------------------------------------------------------------
// lisnoc_link_tx
//
// Sender end of a LISNoC virtual-channel link. Local flits arrive on one
// valid/ready stream per vchannel and are queued in a small FIFO per vchannel.
// Each cycle a round-robin arbiter picks one vchannel whose FIFO is non-empty
// and whose downstream ready bit is set, and drives its head flit onto the
// link. Any cycle with a link_valid bit set is a completed transfer.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous, active-high reset
//   in_flit     local flits, vchannel v in slice v (data_width+type_width bits)
//   in_valid    local flit valid, one bit per vchannel
//   in_ready    FIFO v can accept a flit this cycle (depends on state only)
//   link_flit   flit driven onto the link (zero when nothing is granted)
//   link_valid  one-hot or zero, vchannel of the flit on link_flit
//   link_ready  receiver can take a flit on vchannel v this cycle
// -----------------------------------------------------------------------------
module lisnoc_link_tx #(
    parameter int data_width   = 32,
    parameter int type_width   = 2,
    parameter int vchannels    = 1,
    parameter int buffer_depth = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [vchannels*(data_width+type_width)-1:0]  in_flit,
    input  logic [vchannels-1:0]                          in_valid,
    output logic [vchannels-1:0]                          in_ready,
    output logic [data_width+type_width-1:0]              link_flit,
    output logic [vchannels-1:0]                          link_valid,
    input  logic [vchannels-1:0]                          link_ready
);

    localparam int FW = data_width + type_width;
    localparam int PW = $clog2(buffer_depth);
    localparam int CW = $clog2(buffer_depth + 1);
    localparam int GW = (vchannels > 1) ? $clog2(vchannels) : 1;

    logic [vchannels-1:0][FW-1:0] head;
    logic [vchannels-1:0]         empty;
    logic [vchannels-1:0]         full;
    logic [vchannels-1:0]         push;
    logic [vchannels-1:0]         pop;
    logic [vchannels-1:0]         cand;

    logic [GW-1:0] last_grant;
    logic [GW-1:0] grant_idx;
    logic [GW-1:0] scan_idx;
    logic          grant_any;

    for (genvar v = 0; v < vchannels; v++) begin : g_vc
        logic [FW-1:0] mem [buffer_depth];
        logic [PW-1:0] wptr;
        logic [PW-1:0] rptr;
        logic [CW-1:0] count;

        assign empty[v]    = (count == '0);
        assign full[v]     = (count == CW'(buffer_depth));
        // Ready comes from the registered count only; a pop in a full cycle
        // frees the slot for the next cycle, not this one.
        assign in_ready[v] = !rst && !full[v];
        assign push[v]     = in_valid[v] && in_ready[v];
        assign pop[v]      = link_valid[v];
        assign head[v]     = mem[rptr];

        // Payload storage carries no reset; only the pointers/count define
        // which entries are live.
        always_ff @(posedge clk) begin
            if (push[v]) begin
                mem[wptr] <= in_flit[v*FW +: FW];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                // Explicit wrap so non-power-of-two depths work.
                if (push[v]) begin
                    wptr <= (wptr == PW'(buffer_depth - 1)) ? '0 : wptr + PW'(1);
                end
                if (pop[v]) begin
                    rptr <= (rptr == PW'(buffer_depth - 1)) ? '0 : rptr + PW'(1);
                end
                case ({push[v], pop[v]})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign cand = ~empty & link_ready & {vchannels{!rst}};

    // Round-robin scan: start one past the last granted vchannel and take the
    // first candidate, wrapping modulo vchannels.
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        scan_idx   = '0;
        link_valid = '0;
        link_flit  = '0;
        for (int i = 1; i <= vchannels; i++) begin
            scan_idx = GW'((int'(last_grant) + i) % vchannels);
            if (!grant_any && cand[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (grant_any) begin
            link_valid[grant_idx] = 1'b1;
            link_flit             = head[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GW'(vchannels - 1);
        end else if (grant_any) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: tb/tb_lisnoc_link_tx.sv
// -----------------------------------------------------------------------------
// tb_lisnoc_link_tx
//
// Directed bench for lisnoc_link_tx with three vchannels and depth-2 FIFOs.
// A table of single-cycle vectors covers reset, latency and full-FIFO
// behaviour on vchannel 0; hand-written sequences cover round-robin order,
// a masked ready bit raised mid-stream, continuous push/pop and mid-run reset.
// Flit contents for the sequences are tracked in per-vchannel queues.
// -----------------------------------------------------------------------------
module tb_lisnoc_link_tx;

    localparam int DW = 32;
    localparam int TW = 2;
    localparam int VC = 3;
    localparam int FW = DW + TW;

    logic               clk;
    logic               rst;
    logic [VC*FW-1:0]   in_flit;
    logic [VC-1:0]      in_valid;
    logic [VC-1:0]      in_ready;
    logic [FW-1:0]      link_flit;
    logic [VC-1:0]      link_valid;
    logic [VC-1:0]      link_ready;

    int checks   = 0;
    int failures = 0;

    logic [FW-1:0] sb [VC][$];

    lisnoc_link_tx #(
        .data_width   (DW),
        .type_width   (TW),
        .vchannels    (VC),
        .buffer_depth (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_flit    (in_flit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .link_flit  (link_flit),
        .link_valid (link_valid),
        .link_ready (link_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [VC-1:0] iv;
        logic [31:0]   d;
        logic [VC-1:0] lr;
        logic [VC-1:0] ir;
        logic [VC-1:0] lv;
        logic [FW-1:0] lf;
    } vec_t;

    vec_t tbl [12];

    // Flit for vchannel v built from base value d: type = v, data = d + 0x100*v.
    function automatic logic [FW-1:0] fl(input int v, input logic [31:0] d);
        logic [1:0] t;
        t = 2'(v);
        return {t, d + 32'(256 * v)};
    endfunction

    function automatic logic [VC*FW-1:0] bld(input logic [31:0] d);
        logic [VC*FW-1:0] r;
        r = '0;
        for (int v = 0; v < VC; v++) r[v*FW +: FW] = fl(v, d);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [VC-1:0] iv, input logic [31:0] d,
                         input logic [VC-1:0] lr);
        rst        = r;
        in_valid   = iv;
        in_flit    = bld(d);
        link_ready = lr;
        #1;
    endtask

    // Compare link outputs against the expected grant; flit comes from the queue.
    task automatic expect_link(input string name, input logic [VC-1:0] exp_lv);
        logic [FW-1:0] exp_f;
        int vc;
        exp_f = '0;
        vc = -1;
        for (int v = 0; v < VC; v++) if (exp_lv[v]) vc = v;
        if (vc >= 0 && sb[vc].size() > 0) exp_f = sb[vc].pop_front();
        chk({name, "_valid"}, 64'(link_valid), 64'(exp_lv));
        chk({name, "_flit"},  64'(link_flit),  64'(exp_f));
    endtask

    task automatic do_reset(input logic [VC-1:0] lr);
        drive(1'b1, '0, 32'h0, lr);
        chk("rst_in_ready",   64'(in_ready),   64'(0));
        chk("rst_link_valid", 64'(link_valid), 64'(0));
        chk("rst_link_flit",  64'(link_flit),  64'(0));
        tick();
        for (int v = 0; v < VC; v++) sb[v].delete();
    endtask

    task automatic load_all(input logic [31:0] d);
        drive(1'b0, 3'b111, d, 3'b000);
        for (int v = 0; v < VC; v++) sb[v].push_back(fl(v, d));
        tick();
    endtask

    initial begin
        logic [VC-1:0] seq_lv [7];
        logic [VC-1:0] seq_lr [7];

        rst = 1'b1; in_valid = '0; in_flit = '0; link_ready = '0;
        tick();

        //            rst   iv      d          lr      ir      lv      lf
        tbl[0]  = '{1'b1, 3'b000, 32'h00, 3'b111, 3'b000, 3'b000, 34'h0};
        tbl[1]  = '{1'b1, 3'b001, 32'h05, 3'b111, 3'b000, 3'b000, 34'h0};
        tbl[2]  = '{1'b0, 3'b001, 32'h01, 3'b001, 3'b111, 3'b000, 34'h0};
        tbl[3]  = '{1'b0, 3'b000, 32'h00, 3'b001, 3'b111, 3'b001, 34'h01};
        tbl[4]  = '{1'b0, 3'b000, 32'h00, 3'b001, 3'b111, 3'b000, 34'h0};
        tbl[5]  = '{1'b0, 3'b001, 32'h11, 3'b000, 3'b111, 3'b000, 34'h0};
        tbl[6]  = '{1'b0, 3'b001, 32'h12, 3'b000, 3'b111, 3'b000, 34'h0};
        tbl[7]  = '{1'b0, 3'b001, 32'h13, 3'b000, 3'b110, 3'b000, 34'h0};
        tbl[8]  = '{1'b0, 3'b001, 32'h13, 3'b001, 3'b110, 3'b001, 34'h11};
        tbl[9]  = '{1'b0, 3'b001, 32'h13, 3'b001, 3'b111, 3'b001, 34'h12};
        tbl[10] = '{1'b0, 3'b000, 32'h00, 3'b001, 3'b111, 3'b001, 34'h13};
        tbl[11] = '{1'b0, 3'b000, 32'h00, 3'b111, 3'b111, 3'b000, 34'h0};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].lr);
            chk($sformatf("vec%0d_in_ready", i),   64'(in_ready),   64'(tbl[i].ir));
            chk($sformatf("vec%0d_link_valid", i), 64'(link_valid), 64'(tbl[i].lv));
            chk($sformatf("vec%0d_link_flit", i),  64'(link_flit),  64'(tbl[i].lf));
            tick();
        end

        // Round-robin across all three vchannels from a fresh reset.
        do_reset(3'b000);
        load_all(32'h20);
        load_all(32'h21);
        seq_lv = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, '0, 32'h0, 3'b111);
            expect_link($sformatf("rr%0d", k), seq_lv[k]);
            tick();
        end

        // vchannel 1 masked, then ready raised mid-stream.
        load_all(32'h30);
        load_all(32'h31);
        seq_lr = '{3'b101, 3'b101, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
        seq_lv = '{3'b001, 3'b100, 3'b001, 3'b010, 3'b100, 3'b010, 3'b000};
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, '0, 32'h0, seq_lr[k]);
            expect_link($sformatf("mask%0d", k), seq_lv[k]);
            tick();
        end

        // Continuous push and pop on vchannel 0 for 20 cycles.
        for (int k = 0; k <= 20; k++) begin
            drive(1'b0, (k < 20) ? 3'b001 : 3'b000, 32'h40 + 32'(k), 3'b001);
            chk($sformatf("stream%0d_in_ready", k), 64'(in_ready), 64'(3'b111));
            expect_link($sformatf("stream%0d", k), (k >= 1) ? 3'b001 : 3'b000);
            if (k < 20) sb[0].push_back(fl(0, 32'h40 + 32'(k)));
            tick();
        end

        // Reset while all FIFOs hold flits.
        drive(1'b0, 3'b111, 32'h50, 3'b000);
        tick();
        do_reset(3'b111);
        drive(1'b0, '0, 32'h0, 3'b111);
        chk("postrst_in_ready",   64'(in_ready),   64'(3'b111));
        chk("postrst_link_valid", 64'(link_valid), 64'(0));
        chk("postrst_link_flit",  64'(link_flit),  64'(0));
        tick();
        load_all(32'h60);
        seq_lv[0] = 3'b001; seq_lv[1] = 3'b010; seq_lv[2] = 3'b100; seq_lv[3] = 3'b000;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 32'h0, 3'b111);
            expect_link($sformatf("after_rst%0d", k), seq_lv[k]);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
